// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and writeback stage of the 5-stage
// RV32I core. Captures the M-stage instruction, holds loads until the data
// memory answers, formats load data and drives the register-file write port.
//
// Optional feature macro: WB_RETIRE_COUNT_EN (64-bit retired-instruction counter).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   valid_m .. imm_val_m  M-stage instruction fields
//   dmem_rsp_valid      data memory read response valid
//   dmem_rdata          aligned 32-bit read word
//   stall_m             freezes M and earlier stages while a load is pending
//   reg_write_w, rd_w, result_w  register-file write port
//   instret_w           retired-instruction count (0 when feature disabled)
module writeback_stage #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_m,
    input  logic                     reg_write_m,
    input  logic [1:0]               res_src_m,
    input  logic [4:0]               rd_m,
    input  logic [2:0]               funct3_m,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    input  logic [DATA_WIDTH-1:0]    imm_val_m,
    input  logic                     dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic                     stall_m,
    output logic                     reg_write_w,
    output logic [4:0]               rd_w,
    output logic [DATA_WIDTH-1:0]    result_w,
    output logic [63:0]              instret_w
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMMIT  = 2'd1,
        S_WAIT_LD = 2'd2
    } state_t;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_accept;

    logic                     r_reg_write_q;
    logic [1:0]               r_res_src_q;
    logic [4:0]               r_rd_q;
    logic [2:0]               r_funct3_q;
    logic [1:0]               r_addr_q;
    logic [DATA_WIDTH-1:0]    r_alu_q;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4_q;
    logic [DATA_WIDTH-1:0]    r_imm_q;
    logic [DATA_WIDTH-1:0]    r_load_q;

    logic [DATA_WIDTH-1:0]    w_shifted;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_load_fmt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: WAIT_LD blocks acceptance until the read response
    always_comb begin
        w_state_next = r_state;
        w_accept     = (r_state != S_WAIT_LD);
        case (r_state)
            S_WAIT_LD: begin
                if (dmem_rsp_valid) begin
                    w_state_next = S_COMMIT;
                end
            end
            default: begin
                if (valid_m) begin
                    w_state_next = (res_src_m == RES_LOAD) ? S_WAIT_LD : S_COMMIT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // Load lane selection and extension; a[0] is irrelevant for halves
    always_comb begin
        w_shifted  = dmem_rdata >> {r_addr_q, 3'b000};
        w_byte     = w_shifted[7:0];
        w_half     = r_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_fmt = dmem_rdata;
        case (r_funct3_q)
            3'b000:  w_load_fmt = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_fmt = DATA_WIDTH'(w_byte);
            3'b101:  w_load_fmt = DATA_WIDTH'(w_half);
            default: w_load_fmt = dmem_rdata;
        endcase
    end

    // Capture registers and load data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write_q <= 1'b0;
            r_res_src_q   <= 2'b00;
            r_rd_q        <= 5'd0;
            r_funct3_q    <= 3'b000;
            r_addr_q      <= 2'b00;
            r_alu_q       <= '0;
            r_pc_plus4_q  <= '0;
            r_imm_q       <= '0;
            r_load_q      <= '0;
        end else begin
            if (w_accept) begin
                r_reg_write_q <= reg_write_m;
                r_res_src_q   <= res_src_m;
                r_rd_q        <= rd_m;
                r_funct3_q    <= funct3_m;
                r_addr_q      <= alu_result_m[1:0];
                r_alu_q       <= alu_result_m;
                r_pc_plus4_q  <= pc_plus4_m;
                r_imm_q       <= imm_val_m;
            end
            if ((r_state == S_WAIT_LD) && dmem_rsp_valid) begin
                r_load_q <= w_load_fmt;
            end
        end
    end

    // Writeback port; x0 writes suppressed
    assign stall_m     = (r_state == S_WAIT_LD);
    assign reg_write_w = (r_state == S_COMMIT) && r_reg_write_q && (r_rd_q != 5'd0);
    assign rd_w        = r_rd_q;

    always_comb begin
        case (r_res_src_q)
            RES_ALU:  result_w = r_alu_q;
            RES_LOAD: result_w = r_load_q;
            RES_PC4:  result_w = DATA_WIDTH'(r_pc_plus4_q);
            default:  result_w = r_imm_q;
        endcase
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] r_instret;

    // Counts every committed instruction, including suppressed writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= 64'd0;
        end else if (r_state == S_COMMIT) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret_w = r_instret;
`else
    assign instret_w = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a scoreboard of expected commits.
module tb_writeback_stage;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_m;
    logic          reg_write_m;
    logic [1:0]    res_src_m;
    logic [4:0]    rd_m;
    logic [2:0]    funct3_m;
    logic [DW-1:0] alu_result_m;
    logic [AW-1:0] pc_plus4_m;
    logic [DW-1:0] imm_val_m;
    logic          dmem_rsp_valid;
    logic [DW-1:0] dmem_rdata;
    logic          stall_m;
    logic          reg_write_w;
    logic [4:0]    rd_w;
    logic [DW-1:0] result_w;
    logic [63:0]   instret_w;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   n_commit = 0;

    always #5 clk = ~clk;

    writeback_stage #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_m        (valid_m),
        .reg_write_m    (reg_write_m),
        .res_src_m      (res_src_m),
        .rd_m           (rd_m),
        .funct3_m       (funct3_m),
        .alu_result_m   (alu_result_m),
        .pc_plus4_m     (pc_plus4_m),
        .imm_val_m      (imm_val_m),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .stall_m        (stall_m),
        .reg_write_w    (reg_write_w),
        .rd_w           (rd_w),
        .result_w       (result_w),
        .instret_w      (instret_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        valid_m      = 1'b0;
        reg_write_m  = 1'b0;
        res_src_m    = 2'b00;
        rd_m         = 5'd0;
        funct3_m     = 3'b000;
        alu_result_m = '0;
        pc_plus4_m   = '0;
        imm_val_m    = '0;
    endtask

    task automatic drive(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] imm);
        valid_m      = 1'b1;
        reg_write_m  = rw;
        res_src_m    = src;
        rd_m         = rd;
        funct3_m     = f3;
        alu_result_m = alu;
        pc_plus4_m   = pc;
        imm_val_m    = imm;
    endtask

    task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.we   = we;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // Called on a cycle where the DUT is known to be committing
    task automatic pop_check(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty at commit, observed rd=%0d", tag, rd_w);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".we"},   64'(reg_write_w), 64'(e.we));
            check({tag, ".rd"},   64'(rd_w),        64'(e.rd));
            check({tag, ".data"}, 64'(result_w),    64'(e.data));
            n_commit++;
        end
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input int waits, input logic [31:0] exp);
        drive(1'b1, 2'b01, rd, f3, addr, 32'h0, 32'h0);
        push(rd != 5'd0, rd, exp);
        tick();
        for (int i = 0; i < waits; i++) begin
            check({tag, ".stall"},   64'(stall_m),     64'd1);
            check({tag, ".nowrite"}, 64'(reg_write_w), 64'd0);
            dmem_rsp_valid = (i == waits - 1);
            tick();
        end
        dmem_rsp_valid = 1'b0;
        check({tag, ".unstall"}, 64'(stall_m), 64'd0);
        pop_check(tag);
        set_idle();
        tick();
        check({tag, ".one_cycle"}, 64'(reg_write_w), 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h80FF_1122;
        set_idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst.we",      64'(reg_write_w), 64'd0);
        check("rst.stall",   64'(stall_m),     64'd0);
        check("rst.rd",      64'(rd_w),        64'd0);
        check("rst.result",  64'(result_w),    64'd0);
        check("rst.instret", instret_w,        64'd0);

        // Idle for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle.we",     64'(reg_write_w), 64'd0);
            check("idle.stall",  64'(stall_m),     64'd0);
            check("idle.result", 64'(result_w),    64'd0);
        end

        // Single ALU op
        drive(1'b1, 2'b00, 5'd5, 3'b000, 32'h1234, 32'h0, 32'h0);
        push(1'b1, 5'd5, 32'h1234);
        tick();
        pop_check("alu1");
        set_idle();
        tick();
        check("alu1.one_cycle", 64'(reg_write_w), 64'd0);

        // Three back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 5'(20 + i), 3'b000, 32'hA000 + 32'(i), 32'h0, 32'h0);
            push(1'b1, 5'(20 + i), 32'hA000 + 32'(i));
            tick();
            pop_check("alu3");
        end
        set_idle();
        tick();
        check("alu3.end", 64'(reg_write_w), 64'd0);

        // Loads against word 0x80FF_1122
        do_load("lb_off3",   5'd7,  3'b000, 32'h1003, 4, 32'hFFFF_FF80);
        do_load("lhu_off2",  5'd8,  3'b101, 32'h2002, 4, 32'h0000_80FF);
        do_load("lh_off2",   5'd9,  3'b001, 32'h2002, 1, 32'hFFFF_80FF);
        do_load("lh_off1",   5'd9,  3'b001, 32'h1001, 1, 32'h0000_1122);
        do_load("lbu_off1",  5'd10, 3'b100, 32'h1001, 2, 32'h0000_0011);
        do_load("lw_off1",   5'd11, 3'b010, 32'h1001, 1, 32'h80FF_1122);
        do_load("ld_undef",  5'd12, 3'b110, 32'h1002, 3, 32'h80FF_1122);

        // jal then lui to x0, back to back
        drive(1'b1, 2'b10, 5'd1, 3'b000, 32'h0, 32'h104, 32'h0);
        push(1'b1, 5'd1, 32'h104);
        tick();
        pop_check("jal");
        drive(1'b1, 2'b11, 5'd0, 3'b000, 32'h0, 32'h0, 32'hABCD_0000);
        push(1'b0, 5'd0, 32'hABCD_0000);
        tick();
        pop_check("lui_x0");
        set_idle();
        tick();

        // Reset aborts a pending load
        drive(1'b1, 2'b01, 5'd9, 3'b010, 32'h3000, 32'h0, 32'h0);
        tick();
        check("abort.stall_before", 64'(stall_m), 64'd1);
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        n_commit = 0;
        check("abort.stall",   64'(stall_m),     64'd0);
        check("abort.we",      64'(reg_write_w), 64'd0);
        check("abort.rd",      64'(rd_w),        64'd0);
        check("abort.result",  64'(result_w),    64'd0);
        check("abort.instret", instret_w,        64'd0);
        dmem_rsp_valid = 1'b1;
        tick();
        dmem_rsp_valid = 1'b0;
        check("idle_rsp.we",     64'(reg_write_w), 64'd0);
        check("idle_rsp.stall",  64'(stall_m),     64'd0);
        check("idle_rsp.result", 64'(result_w),    64'd0);
        tick();
        check("idle_rsp.we2", 64'(reg_write_w), 64'd0);

        // Seven commits including one write to x0
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 2'b00, (i == 3) ? 5'd0 : 5'(10 + i), 3'b000,
                  32'h5000 + 32'(i * 17), 32'h0, 32'h0);
            push(i != 3, (i == 3) ? 5'd0 : 5'(10 + i), 32'h5000 + 32'(i * 17));
            tick();
            pop_check("retire");
        end
        set_idle();
        tick();
`ifdef WB_RETIRE_COUNT_EN
        check("instret", instret_w, 64'(n_commit));
        check("instret7", instret_w, 64'd7);
`else
        check("instret_off", instret_w, 64'd0);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d expected=0 pending entries", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
